// File: rtl/freq_meter.sv
// freq_meter: gate-window frequency meter.
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// system clocks and publishes the count, with a one-cycle valid pulse and a
// saturation flag, once per completed window. With the default parameters
// and a 50 MHz clock the published count reads directly in Hz.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int COUNT_WIDTH = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] freq_count,
  output logic                   freq_valid,
  output logic                   overflow
);

  // The gate counter only has to reach GATE_CYCLES-1.
  localparam int GATE_WIDTH = $clog2(GATE_CYCLES);
  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [GATE_WIDTH-1:0]  GATE_ONE  = GATE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  // Synchronizer chain and edge-detect history.
  logic                   r_s1;
  logic                   r_s2;
  logic                   r_s3;

  // Window state.
  logic [GATE_WIDTH-1:0]  r_gate_cnt;
  logic [COUNT_WIDTH-1:0] r_edge_cnt;
  logic                   r_sat;

  // Registered outputs.
  logic [COUNT_WIDTH-1:0] r_freq_count;
  logic                   r_freq_valid;
  logic                   r_overflow;

  // Combinational helpers.
  logic                   w_edge;
  logic                   w_terminal;
  logic                   w_cnt_full;
  logic                   w_add_sat;
  logic                   w_close;
  logic [COUNT_WIDTH-1:0] w_edge_next;

  // A rising edge is a synchronized high sample whose predecessor was low.
  assign w_edge      = r_s2 & ~r_s3;

  // Last cycle of the window; only meaningful while enabled.
  assign w_terminal  = (r_gate_cnt == GATE_LAST);
  assign w_close     = enable & w_terminal;

  // The counter sticks at all-ones; an edge arriving while full is lost and
  // marks the window as saturated.
  assign w_cnt_full  = (r_edge_cnt == COUNT_MAX);
  assign w_add_sat   = w_edge & w_cnt_full;
  assign w_edge_next = (w_edge && !w_cnt_full) ? (r_edge_cnt + COUNT_ONE) : r_edge_cnt;

  assign freq_count  = r_freq_count;
  assign freq_valid  = r_freq_valid;
  assign overflow    = r_overflow;

  // Two-flop synchronizer plus history flop, free-running regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Gate counter: runs 0..GATE_CYCLES-1 while enabled, cleared while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_cnt <= '0;
    end else if (!enable) begin
      r_gate_cnt <= '0;
    end else if (w_terminal) begin
      r_gate_cnt <= '0;
    end else begin
      r_gate_cnt <= r_gate_cnt + GATE_ONE;
    end
  end

  // Edge counter and saturation flag; both restart clean at each window close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (!enable || w_terminal) begin
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_edge_cnt <= w_edge_next;
      if (w_add_sat) begin
        r_sat <= 1'b1;
      end
    end
  end

  // Publish the closing window's count (including a terminal-cycle edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freq_count <= '0;
      r_freq_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_freq_valid <= w_close;
      if (w_close) begin
        r_freq_count <= w_edge_next;
        r_overflow   <= r_sat | w_add_sat;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized scoreboard bench for freq_meter.
// Two instances (8-bit and 5-bit counters, 100-cycle window) share one
// stimulus stream; a reference model pushes the expected report of every
// window and a monitor pops it when the outputs should present it.
module tb_freq_meter;

  localparam int GATE = 100;
  localparam int MAX8 = 255;
  localparam int MAX5 = 31;

  logic       clk;
  logic       rst;
  logic       sig_in;
  logic       enable;
  logic [7:0] fc8;
  logic       fv8;
  logic       ov8;
  logic [4:0] fc5;
  logic       fv5;
  logic       ov5;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int validCount  = 0;

  // Stimulus generator controls: 0 low, 1 high, 2 periodic, 3 random.
  int mode = 0;
  int per  = 10;
  int half = 5;
  int ph   = 0;

  typedef struct {
    int cnt8;
    int ov8;
    int cnt5;
    int ov5;
    int cyc;
  } exp_t;

  exp_t expQ[$];

  // Reference model state: last three sampled inputs, enabled cycles in the
  // current window, and edges seen so far in that window.
  logic [2:0] hist;
  int mwin;
  int medges;

  int last8  = 0;
  int lastO8 = 0;
  int last5  = 0;
  int lastO5 = 0;

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .enable     (enable),
    .freq_count (fc8),
    .freq_valid (fv8),
    .overflow   (ov8)
  );

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_WIDTH(5)) dut5 (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .enable     (enable),
    .freq_count (fc5),
    .freq_valid (fv5),
    .overflow   (ov5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle number used to time-stamp expected reports.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitValids(input int n);
    int target;
    int budget;
    target = validCount + n;
    budget = n * GATE + 200;
    while (validCount < target && budget > 0) begin
      applyStimulus(1);
      budget--;
    end
    if (validCount < target) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL wait_valid: got %0d reports, expected %0d", validCount, target);
    end
  endtask

  task automatic waitWin(input int target);
    int budget;
    budget = 3 * GATE;
    while (mwin != target && budget > 0) begin
      applyStimulus(1);
      budget--;
    end
    if (mwin != target) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL wait_window: got position %0d, expected %0d", mwin, target);
    end
  endtask

  function automatic exp_t makeExp(input int n, input int c);
    exp_t e;
    e.cnt8 = (n > MAX8) ? MAX8 : n;
    e.ov8  = (n > MAX8) ? 1 : 0;
    e.cnt5 = (n > MAX5) ? MAX5 : n;
    e.ov5  = (n > MAX5) ? 1 : 0;
    e.cyc  = c;
    return e;
  endfunction

  // Input waveform driven on falling edges according to the selected mode.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      ph = ph + 1;
      case (mode)
        0:       sig_in = 1'b0;
        1:       sig_in = 1'b1;
        2:       sig_in = ((ph % per) >= half);
        default: sig_in = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: an input rise sampled at edge t is an edge at t+2; each
  // run of GATE enabled cycles closes a window whose report is its edge count
  // clamped to the counter range, due in the cycle after the closing edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist   <= 3'b000;
      mwin   <= 0;
      medges <= 0;
      expQ.delete();
    end else begin
      hist <= {hist[1:0], sig_in};
      if (!enable) begin
        mwin   <= 0;
        medges <= 0;
      end else if (mwin == GATE - 1) begin
        expQ.push_back(makeExp(medges + ((hist[1] && !hist[2]) ? 1 : 0), cyc + 1));
        mwin   <= 0;
        medges <= 0;
      end else begin
        mwin   <= mwin + 1;
        medges <= medges + ((hist[1] && !hist[2]) ? 1 : 0);
      end
    end
  end

  // Monitor: compares each report when due and checks outputs hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last8  = 0;
      lastO8 = 0;
      last5  = 0;
      lastO5 = 0;
    end else if (fv8 || fv5 || (expQ.size() > 0 && cyc >= expQ[0].cyc)) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL spurious_valid: got valid8=%0d valid5=%0d, expected none (cycle %0d)",
                 fv8, fv5, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("valid8", fv8, 1);
        checkOutput("valid5", fv5, 1);
        checkOutput("valid_cycle", cyc, e.cyc);
        checkOutput("count8", fc8, e.cnt8);
        checkOutput("overflow8", ov8, e.ov8);
        checkOutput("count5", fc5, e.cnt5);
        checkOutput("overflow5", ov5, e.ov5);
        last8  = e.cnt8;
        lastO8 = e.ov8;
        last5  = e.cnt5;
        lastO5 = e.ov5;
        validCount++;
      end
    end else begin
      checkOutput("hold_count8", fc8, last8);
      checkOutput("hold_overflow8", ov8, lastO8);
      checkOutput("hold_count5", fc5, last5);
      checkOutput("hold_overflow5", ov5, lastO5);
    end
  end

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 0;
    #1;
    checkOutput("reset_count8", fc8, 0);
    checkOutput("reset_valid8", fv8, 0);
    checkOutput("reset_overflow8", ov8, 0);
    checkOutput("reset_count5", fc5, 0);
    checkOutput("reset_valid5", fv5, 0);
    checkOutput("reset_overflow5", ov5, 0);
    applyStimulus(3);

    // Quiet input: first report after edge 100 reads zero.
    rst    = 1'b0;
    enable = 1'b1;
    waitValids(2);

    // Period-10 input, low at reset release.
    rst  = 1'b1;
    per  = 10;
    half = 5;
    ph   = 0;
    mode = 2;
    applyStimulus(2);
    rst = 1'b0;
    waitValids(3);
    checkOutput("steady_count8", fc8, 10);

    // Drop enable for 20 cycles in mid-window.
    waitWin(50);
    enable = 1'b0;
    applyStimulus(20);
    enable = 1'b1;
    waitValids(2);
    checkOutput("after_drop_count8", fc8, 10);

    // Asynchronous reset between clock edges clears outputs at once.
    waitWin(30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_count8", fc8, 0);
    checkOutput("async_valid8", fv8, 0);
    checkOutput("async_overflow8", ov8, 0);
    checkOutput("async_count5", fc5, 0);

    // Input already high at reset release counts once, then never again.
    mode = 1;
    applyStimulus(2);
    rst = 1'b0;
    waitValids(3);

    // Single rise landing on the terminal cycle.
    mode = 0;
    waitValids(1);
    waitWin(GATE - 3);
    mode = 1;
    waitValids(2);

    // Period-2 input saturates the narrow counter, then a quiet window.
    per  = 2;
    half = 1;
    ph   = 0;
    mode = 2;
    waitValids(3);
    checkOutput("sat_count5", fc5, MAX5);
    checkOutput("sat_overflow5", ov5, 1);
    mode = 0;
    waitValids(2);

    // Randomized input patterns with occasional enable drops.
    repeat (10) begin
      if ($urandom_range(0, 1) == 1) begin
        mode = 3;
      end else begin
        per  = $urandom_range(2, 12);
        half = $urandom_range(1, per - 1);
        mode = 2;
      end
      applyStimulus($urandom_range(20, 180));
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        applyStimulus($urandom_range(1, 40));
        enable = 1'b1;
      end
    end

    // Drain outstanding windows.
    mode = 0;
    waitValids(2);
    applyStimulus(5);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
